// File: rtl/ex_mem_stage_if.sv
// Execute/memory boundary bundle: ALU-side inputs, writeback outputs
// and the fetch redirect, all under one valid/ready handshake.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic [2:0]  in_funct3;
  logic        in_is_branch;
  logic        in_is_jal;
  logic        in_is_jalr;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output in_valid, in_pc, in_target, in_funct3,
    output in_is_branch, in_is_jal, in_is_jalr,
    output in_reg_write, in_rd, alu_result, alu_flags,
    output out_ready,
    input  in_ready, out_valid, out_result, out_rd,
    input  out_reg_write, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_target, in_funct3,
    input  in_is_branch, in_is_jal, in_is_jalr,
    input  in_reg_write, in_rd, alu_result, alu_flags,
    input  out_ready,
    output in_ready, out_valid, out_result, out_rd,
    output out_reg_write, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM register: resolves branches and jumps from ALU flags,
// registers writeback data and pulses a one-cycle fetch redirect.
module ex_mem_stage (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  logic        out_valid_q;
  logic        redir_q;
  logic        we_q;
  logic [31:0] res_q;
  logic [31:0] rpc_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        load;
  logic        br_taken;
  logic        take;
  logic [31:0] tgt;
  logic [31:0] link;
  logic        f_v;
  logic        f_c;
  logic        f_n;
  logic        f_z;

  assign {f_v, f_c, f_n, f_z} = bus.alu_flags;

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready;
  // The instruction handshaken during a redirect is younger: drop it.
  assign load = accept & ~redir_q;
  assign link = bus.in_pc + 32'd4;

  always_comb begin
    br_taken = 1'b0;
    case (bus.in_funct3)
      3'b000:  br_taken = f_z;
      3'b001:  br_taken = ~f_z;
      3'b100:  br_taken = f_n ^ f_v;
      3'b101:  br_taken = ~(f_n ^ f_v);
      3'b110:  br_taken = ~f_c;
      3'b111:  br_taken = f_c;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    tgt  = bus.in_target;
    priority case (1'b1)
      bus.in_is_jal: take = 1'b1;
      bus.in_is_jalr: begin
        take = 1'b1;
        tgt  = {bus.alu_result[31:1], 1'b0};
      end
      bus.in_is_branch: take = br_taken;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      redir_q     <= 1'b0;
      we_q        <= 1'b0;
      res_q       <= '0;
      rpc_q       <= '0;
      rd_q        <= '0;
    end else begin
      if (load)
        out_valid_q <= 1'b1;
      else if (bus.out_ready)
        out_valid_q <= 1'b0;
      redir_q <= load & take;
      if (load) begin
        res_q <= (bus.in_is_jal | bus.in_is_jalr)
               ? link : bus.alu_result;
        rd_q  <= bus.in_rd;
        we_q  <= bus.in_reg_write & (bus.in_rd != 5'd0);
      end
      if (load & take)
        rpc_q <= tgt;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = res_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_reg_write  = we_q;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = rpc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with output and redirect
// scoreboards checked by immediate assertions.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  localparam logic [2:0] K_ALU  = 3'b000;
  localparam logic [2:0] K_BR   = 3'b001;
  localparam logic [2:0] K_JALR = 3'b010;
  localparam logic [2:0] K_JAL  = 3'b100;

  exp_t        out_q[$];
  logic [31:0] rdr_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sub_flags(input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = a - b;
    return {(a[31] != b[31]) && (r[31] != a[31]),
            a >= b, r[31], r == 32'd0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc,
                      input logic [31:0] tgt,
                      input logic [2:0]  f3,
                      input logic [2:0]  kind,
                      input logic        we,
                      input logic [4:0]  rd,
                      input logic [31:0] alu,
                      input logic [3:0]  fl,
                      input bit          sq,
                      input logic [31:0] e_res,
                      input logic        e_we,
                      input bit          e_rdr,
                      input logic [31:0] e_rpc);
    int   k;
    exp_t e;
    bus.in_valid     = 1'b1;
    bus.in_pc        = pc;
    bus.in_target    = tgt;
    bus.in_funct3    = f3;
    bus.in_is_jal    = kind[2];
    bus.in_is_jalr   = kind[1];
    bus.in_is_branch = kind[0];
    bus.in_reg_write = we;
    bus.in_rd        = rd;
    bus.alu_result   = alu;
    bus.alu_flags    = fl;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 50);
    check("accept_in_time", bus.in_ready, 1);
    @(posedge clk);
    if (!sq) begin
      e.res = e_res;
      e.rd  = rd;
      e.we  = e_we;
      out_q.push_back(e);
      if (e_rdr) rdr_q.push_back(e_rpc);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  // Output / redirect monitor, sampled mid-cycle.
  logic        stall_p = 1'b0;
  logic [31:0] res_p;
  logic [4:0]  rd_p;
  exp_t        got_e;
  logic [31:0] got_pc;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_result", bus.out_result, res_p);
        check("hold_rd", bus.out_rd, rd_p);
      end
      if (bus.out_valid && !bus.out_ready)
        check("stall_in_ready", bus.in_ready, 0);
      stall_p = bus.out_valid & ~bus.out_ready;
      res_p   = bus.out_result;
      rd_p    = bus.out_rd;
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", out_q.size() != 0, 1);
        if (out_q.size() != 0) begin
          got_e = out_q.pop_front();
          check("out_result", bus.out_result, got_e.res);
          check("out_rd", bus.out_rd, got_e.rd);
          check("out_reg_write", bus.out_reg_write, got_e.we);
        end
      end
      if (bus.redirect_valid) begin
        check("redirect_expected", rdr_q.size() != 0, 1);
        if (rdr_q.size() != 0) begin
          got_pc = rdr_q.pop_front();
          check("redirect_pc", bus.redirect_pc, got_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [3:0] fz;
  logic [3:0] fneg;
  int         t0;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_target = '0;
    bus.in_funct3 = '0;
    bus.in_is_jal = 1'b0;
    bus.in_is_jalr = 1'b0;
    bus.in_is_branch = 1'b0;
    bus.in_reg_write = 1'b0;
    bus.in_rd = '0;
    bus.alu_result = '0;
    bus.alu_flags = '0;
    bus.out_ready = 1'b1;
    tick(2);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_redirect_valid", bus.redirect_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_rd", bus.out_rd, 0);
    check("rst_out_reg_write", bus.out_reg_write, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    tick(1);

    // BEQ taken, downstream ready
    fz = sub_flags(32'd5, 32'd5);
    send(32'h10, 32'h100, 3'b000, K_BR, 1'b0, 5'd0, 32'd0, fz,
         0, 32'd0, 1'b0, 1, 32'h100);
    check("beq1_pulse", bus.redirect_valid, 1);
    check("beq1_pc", bus.redirect_pc, 32'h100);
    check("beq1_we", bus.out_reg_write, 0);
    tick(1);
    check("beq1_pulse_end", bus.redirect_valid, 0);

    // BEQ taken under 3 cycles of backpressure
    bus.out_ready = 1'b0;
    send(32'h20, 32'h120, 3'b000, K_BR, 1'b0, 5'd0, 32'd0, fz,
         0, 32'd0, 1'b0, 1, 32'h120);
    check("beq2_pulse", bus.redirect_valid, 1);
    tick(1);
    check("beq2_pulse_end", bus.redirect_valid, 0);
    check("beq2_in_ready", bus.in_ready, 0);
    tick(2);
    check("beq2_no_repeat", bus.redirect_valid, 0);
    check("beq2_still_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick(1);
    check("beq2_drained", bus.out_valid, 0);

    // Signed/unsigned compare sweep: A=0xFFFFFFFF, B=1
    fneg = sub_flags(32'hFFFF_FFFF, 32'd1);
    send(32'h30, 32'h200, 3'b100, K_BR, 1'b0, 5'd0,
         32'hFFFF_FFFE, fneg, 0, 32'hFFFF_FFFE, 1'b0, 1, 32'h200);
    check("blt_taken", bus.redirect_valid, 1);
    tick(1);
    send(32'h34, 32'h204, 3'b110, K_BR, 1'b0, 5'd0,
         32'hFFFF_FFFE, fneg, 0, 32'hFFFF_FFFE, 1'b0, 0, 32'h0);
    check("bltu_not_taken", bus.redirect_valid, 0);
    send(32'h38, 32'h208, 3'b101, K_BR, 1'b0, 5'd0,
         32'hFFFF_FFFE, fneg, 0, 32'hFFFF_FFFE, 1'b0, 0, 32'h0);
    check("bge_not_taken", bus.redirect_valid, 0);
    send(32'h3C, 32'h20C, 3'b111, K_BR, 1'b0, 5'd0,
         32'hFFFF_FFFE, fneg, 0, 32'hFFFF_FFFE, 1'b0, 1, 32'h20C);
    check("bgeu_taken", bus.redirect_valid, 1);
    tick(1);
    send(32'h50, 32'h210, 3'b010, K_BR, 1'b0, 5'd0, 32'd0, fz,
         0, 32'd0, 1'b0, 0, 32'h0);
    check("f3_010_not_taken", bus.redirect_valid, 0);
    send(32'h54, 32'h214, 3'b001, K_BR, 1'b0, 5'd0, 32'd0, fz,
         0, 32'd0, 1'b0, 0, 32'h0);
    check("bne_not_taken", bus.redirect_valid, 0);

    // JALR clears bit 0 of the target; JAL link wraps
    send(32'h40, 32'h999, 3'b000, K_JALR, 1'b1, 5'd1,
         32'h0000_1235, 4'd0, 0, 32'h44, 1'b1, 1, 32'h1234);
    check("jalr_pc", bus.redirect_pc, 32'h1234);
    check("jalr_result", bus.out_result, 32'h44);
    check("jalr_we", bus.out_reg_write, 1);
    tick(1);
    send(32'hFFFF_FFFC, 32'h300, 3'b000, K_JAL, 1'b1, 5'd2,
         32'hDEAD_BEEF, 4'd0, 0, 32'h0, 1'b1, 1, 32'h300);
    check("jal_wrap_result", bus.out_result, 32'h0);
    tick(1);

    // Squash: JAL then ADD back-to-back, then a normal ADD
    send(32'h80, 32'h500, 3'b000, K_JAL, 1'b1, 5'd5, 32'd0, 4'd0,
         0, 32'h84, 1'b1, 1, 32'h500);
    send(32'h84, 32'h0, 3'b000, K_ALU, 1'b1, 5'd3, 32'd7, 4'd0,
         1, 32'd7, 1'b1, 0, 32'h0);
    check("squash_not_loaded", bus.out_valid, 0);
    send(32'h500, 32'h0, 3'b000, K_ALU, 1'b1, 5'd4, 32'd9, 4'd0,
         0, 32'd9, 1'b1, 0, 32'h0);
    check("after_squash_loaded", bus.out_result, 32'd9);
    tick(1);

    // Squashed taken branch must not redirect; rd=0 kills write
    send(32'h90, 32'h600, 3'b000, K_JAL, 1'b1, 5'd7, 32'd0, 4'd0,
         0, 32'h94, 1'b1, 1, 32'h600);
    send(32'h94, 32'h700, 3'b000, K_BR, 1'b0, 5'd0, 32'd0, fz,
         1, 32'd0, 1'b0, 0, 32'h0);
    check("squash_no_redirect", bus.redirect_valid, 0);
    send(32'h600, 32'h0, 3'b000, K_ALU, 1'b1, 5'd0, 32'h55, 4'd0,
         0, 32'h55, 1'b0, 0, 32'h0);
    check("rd0_we", bus.out_reg_write, 0);
    tick(2);

    // Eight ADDs with out_ready toggling
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h1000 + 32'(i) * 4, 32'h0, 3'b000, K_ALU, 1'b1,
               5'(i + 1), 32'hA000 + 32'(i), 4'd0, 0,
               32'hA000 + 32'(i), 1'b1, 0, 32'h0);
      end
      begin
        repeat (24) begin
          @(posedge clk);
          #1 bus.out_ready = ~bus.out_ready;
        end
      end
    join
    bus.out_ready = 1'b1;
    tick(3);
    check("bp_all_delivered", out_q.size(), 0);

    // Full throughput with out_ready held high
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      send(32'h2000 + 32'(i) * 4, 32'h0, 3'b000, K_ALU, 1'b1,
           5'(i + 9), 32'hB000 + 32'(i), 4'd0, 0,
           32'hB000 + 32'(i), 1'b1, 0, 32'h0);
    check("throughput_cycles", cyc - t0, 8);
    tick(2);
    check("tp_all_delivered", out_q.size(), 0);

    // Reset with an entry held and a redirect pending
    bus.out_ready = 1'b0;
    send(32'h700, 32'h800, 3'b000, K_JAL, 1'b1, 5'd6, 32'd0, 4'd0,
         0, 32'h704, 1'b1, 1, 32'h800);
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_redirect", bus.redirect_valid, 1);
    out_q.delete();
    rdr_q.delete();
    rst = 1'b1;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_redirect", bus.redirect_valid, 0);
    check("async_rst_result", bus.out_result, 0);
    check("async_rst_pc", bus.redirect_pc, 0);
    tick(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    tick(1);
    check("post_rst_no_pulse", bus.redirect_valid, 0);
    tick(2);
    check("post_rst_no_pulse2", bus.redirect_valid, 0);

    check("out_q_empty", out_q.size(), 0);
    check("rdr_q_empty", rdr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
